hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage core. Drives PC, IF_ID and ID_EX hazard

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, branch/jump flush, data-memory wait with timeout.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TCNT_W      = 5,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_EX_mem_rd,
    input  logic [4:0]        ID_EX_rt,
    input  logic [4:0]        IF_ID_rs,
    input  logic [4:0]        IF_ID_rt,
    input  logic              IF_ID_use_rt,
    input  logic              branch_taken,
    input  logic              jump_ID,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              hazard_PC,
    output logic [1:0]        hazard_IF_ID,
    output logic              hazard_ID_EX,
    output logic              pipe_freeze,
    output logic [1:0]        pc_sel,
    output logic              mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {StRun, StMemWait, StMemErr} state_e;

    state_e              state_q, state_d;
    logic [TCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic                load_use;
    logic                mem_stall;

    assign load_use = ID_EX_mem_rd && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (IF_ID_use_rt && (ID_EX_rt == IF_ID_rt)));
    assign mem_stall = mem_req && !mem_ready;
    assign mem_err   = mem_err_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        hazard_PC    = 1'b0;
        hazard_IF_ID = 2'b00;
        hazard_ID_EX = 1'b0;
        pipe_freeze  = 1'b0;
        pc_sel       = 2'b00;
        unique case (state_q)
            StRun: begin
                // The access cycle itself is the first frozen cycle, so it counts as one wait.
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    state_d     = StMemWait;
                    wait_cnt_d  = TCNT_W'(1);
                end else if (branch_taken) begin
                    pc_sel       = 2'b01;
                    hazard_IF_ID = 2'b10;
                    hazard_ID_EX = 1'b1;
                end else if (load_use) begin
                    hazard_PC    = 1'b1;
                    hazard_IF_ID = 2'b01;
                    hazard_ID_EX = 1'b1;
                end else if (jump_ID) begin
                    pc_sel       = 2'b10;
                    hazard_IF_ID = 2'b10;
                end
            end
            StMemWait: begin
                pipe_freeze = 1'b1;
                if (mem_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TCNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d    = StMemErr;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TCNT_W'(1);
                end
            end
            StMemErr: begin
                pc_sel       = 2'b11;
                hazard_IF_ID = 2'b10;
                hazard_ID_EX = 1'b1;
                state_d      = StRun;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
        // Outputs are combinational on inputs, so they must be masked while reset is held.
        if (!reset) begin
            hazard_PC    = 1'b0;
            hazard_IF_ID = 2'b00;
            hazard_ID_EX = 1'b0;
            pipe_freeze  = 1'b0;
            pc_sel       = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((hazard_PC || pipe_freeze) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if ((hazard_IF_ID == 2'b10) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
